// File: rtl/mips_run_control.sv
// Run/reset sequencer for the pipelined MIPS core: holds the core in reset, then
// watches the fetch address and stops on halt address, PC self-loop or cycle budget.
module mips_run_control #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          CYCLE_WIDTH  = 32,
  parameter int unsigned          RESET_CYCLES = 2,
  parameter logic [PC_WIDTH-1:0]  HALT_ADDR    = PC_WIDTH'(32'hFFFF_FFFC),
  parameter bit                   HALT_EN      = 1'b1,
  parameter int unsigned          STALL_LIMIT  = 8,
  parameter int unsigned          MAX_CYCLES   = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic [PC_WIDTH-1:0]    pc_addr,
  output logic                   core_reset,
  output logic                   running,
  output logic                   done,
  output logic [1:0]             status,
  output logic [CYCLE_WIDTH-1:0] cycles
);

  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;
  typedef enum logic [1:0] {ST_NONE, ST_HALT, ST_LOOP, ST_TIMEOUT} status_t;

  localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

  localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0]     STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [CYCLE_WIDTH-1:0] CYCLE_LAST = CYCLE_WIDTH'(MAX_CYCLES - 1);

  state_t               state;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [STALL_W-1:0]   stall_cnt;
  logic [PC_WIDTH-1:0]  last_pc;
  logic                 last_valid;

  logic                 pc_match;
  logic                 halt_hit;
  logic                 loop_hit;
  logic                 timeout_hit;
  logic                 fire;
  status_t              win_status;
  logic [CYCLE_WIDTH-1:0] cycles_next;

  assign pc_match    = (STALL_LIMIT != 0) && last_valid && (pc_addr == last_pc);
  assign halt_hit    = HALT_EN && (pc_addr == HALT_ADDR);
  assign loop_hit    = pc_match && (stall_cnt == STALL_LAST);
  assign timeout_hit = (MAX_CYCLES != 0) && (cycles == CYCLE_LAST);
  assign fire        = halt_hit || loop_hit || timeout_hit;

  // With no budget the counter pins at all-ones instead of wrapping back to zero.
  assign cycles_next = ((MAX_CYCLES == 0) && (&cycles)) ? cycles : cycles + 1'b1;

  always_comb begin
    // NOTE: assign a default before the branches so no path leaves the signal
    // unassigned; otherwise synthesis infers a latch.
    win_status = ST_NONE;
    if (halt_hit)         win_status = ST_HALT;
    else if (loop_hit)    win_status = ST_LOOP;
    else if (timeout_hit) win_status = ST_TIMEOUT;
  end

  // NOTE: last_pc is a plain data register with no reset; last_valid gates every
  // use of it, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (state == RUN) last_pc <= pc_addr;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      stall_cnt  <= '0;
      last_valid <= 1'b0;
      core_reset <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
      status     <= ST_NONE;
      cycles     <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
            last_valid <= 1'b0;
            stall_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          cycles     <= cycles_next;
          last_valid <= 1'b1;
          stall_cnt  <= pc_match ? stall_cnt + 1'b1 : '0;
          if (fire) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            status  <= win_status;
          end
        end
        DONE: begin
          // Results stay frozen until restart or reset.
        end
        default: begin
          state      <= HOLD;
          hold_cnt   <= '0;
          core_reset <= 1'b1;
          running    <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_control.sv
// Randomised bench for mips_run_control against a run-level behavioural model,
// plus directed halt / self-loop / timeout / restart / reset scenarios.
module tb_mips_run_control;

  localparam int          RC   = 2;
  localparam int          SL   = 8;
  localparam int          MC   = 20;
  localparam logic [31:0] HALT = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] pc_addr = '0;
  logic        core_reset;
  logic        running;
  logic        done;
  logic [1:0]  status;
  logic [31:0] cycles;

  int total = 0;
  int bad   = 0;

  // Model state: phase 0 = holding, 1 = running, 2 = finished.
  int          m_phase  = 0;
  int          m_held   = 0;
  int          m_status = 0;
  int          m_cycles = 0;
  logic [31:0] m_last   = '0;
  bit          m_have   = 1'b0;
  int          m_same   = 0;
  logic [31:0] prev_pc  = '0;

  mips_run_control #(
    .PC_WIDTH    (32),
    .CYCLE_WIDTH (32),
    .RESET_CYCLES(RC),
    .HALT_ADDR   (HALT),
    .HALT_EN     (1'b1),
    .STALL_LIMIT (SL),
    .MAX_CYCLES  (MC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .pc_addr   (pc_addr),
    .core_reset(core_reset),
    .running   (running),
    .done      (done),
    .status    (status),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of the reference: the run ends on a halt address, on
  // SL+1 identical consecutive samples, or once MC run edges have elapsed.
  task automatic model_edge();
    bit halt, loop, tmo;
    if (!rst_n || restart) begin
      m_phase = 0; m_held = 0; m_status = 0; m_cycles = 0; m_have = 0; m_same = 0;
    end else if (m_phase == 0) begin
      m_held++;
      if (m_held == RC) m_phase = 1;
    end else if (m_phase == 1) begin
      m_cycles++;
      if (m_have && pc_addr == m_last) m_same++;
      else m_same = 1;
      m_last = pc_addr;
      m_have = 1'b1;
      halt = (pc_addr == HALT);
      loop = (m_same >= SL + 1);
      tmo  = (m_cycles == MC);
      if (halt)      m_status = 1;
      else if (loop) m_status = 2;
      else if (tmo)  m_status = 3;
      if (halt || loop || tmo) m_phase = 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("core_reset", core_reset, m_phase == 0);
    check("running",    running,    m_phase == 1);
    check("done",       done,       m_phase == 2);
    check("status",     status,     m_status);
    check("cycles",     cycles,     m_cycles);
  endtask

  function automatic logic [31:0] pick_pc(input int mode, input int k);
    logic [31:0] p;
    case (mode)
      0:       p = (k == 10) ? HALT : 32'(4 * (k - 1));
      1:       p = (k < 3) ? 32'(4 * (k - 1)) : 32'h40;
      2:       p = 32'(4 * (k - 1));
      3:       p = (k == 20) ? HALT : 32'(4 * (k - 1));
      4:       p = (k < 12) ? 32'(4 * (k - 1)) : 32'h80;
      5:       p = 32'(4 * ((k - 1) / 2));
      default: begin
        if ($urandom_range(15) == 0)     p = HALT;
        else if ($urandom_range(3) != 0) p = prev_pc;
        else                             p = 32'($urandom_range(7) * 4);
      end
    endcase
    return p;
  endfunction

  // Drive a pc pattern indexed by the upcoming run edge until the run ends or the bound expires.
  task automatic run_mode(input int mode, input int bound);
    for (int i = 0; i < bound && m_phase != 2; i++) begin
      if (m_phase == 1) pc_addr = pick_pc(mode, m_cycles + 1);
      else              pc_addr = (mode == 6) ? $urandom : 32'h0;
      prev_pc = pc_addr;
      if (mode == 6) begin
        restart = ($urandom_range(63) == 0);
        rst_n   = ($urandom_range(127) != 0);
      end
      tick();
      restart = 1'b0;
      rst_n   = 1'b1;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_core_reset", core_reset, 1);
    check("rst_cycles",     cycles,     0);
    check("rst_status",     status,     0);

    // Release: two hold edges, then pc climbs by 4 and reaches the halt address on run edge 10.
    rst_n = 1'b1;
    tick();
    check("hold1_core_reset", core_reset, 1);
    tick();
    check("hold2_running", running, 1);
    check("hold2_cycles",  cycles,  0);
    run_mode(0, 40);
    check("halt_done",   done,   1);
    check("halt_status", status, 1);
    check("halt_cycles", cycles, 10);

    // Restart from the finished state, then a self-loop at 0x40 from run edge 3.
    pulse_restart();
    check("rs_done_status",     status,     0);
    check("rs_done_cycles",     cycles,     0);
    check("rs_done_core_reset", core_reset, 1);
    tick();
    tick();
    check("rs_done_running", running, 1);
    run_mode(1, 40);
    check("loop_status", status, 2);
    check("loop_cycles", cycles, 11);

    // Restart while holding extends the hold.
    pulse_restart();
    tick();
    pulse_restart();
    tick();
    check("rs_hold_extended", core_reset, 1);
    tick();
    check("rs_hold_run", running, 1);
    run_mode(2, 40);
    check("tmo_done",   done,   1);
    check("tmo_status", status, 3);
    check("tmo_cycles", cycles, 20);

    // Halt on the budget edge wins over timeout.
    pulse_restart();
    run_mode(3, 60);
    check("halt_tmo_status", status, 1);
    check("halt_tmo_cycles", cycles, 20);

    // Self-loop completing on the budget edge wins over timeout.
    pulse_restart();
    run_mode(4, 60);
    check("loop_tmo_status", status, 2);
    check("loop_tmo_cycles", cycles, 20);

    // Every pc repeated once, like pipeline bubbles, never counts as a loop.
    pulse_restart();
    run_mode(5, 60);
    check("bubble_status", status, 3);

    // System reset in the middle of a run.
    pulse_restart();
    run_mode(2, 7);
    check("midrun_running", running, 1);
    rst_n = 1'b0;
    tick();
    check("midrun_core_reset", core_reset, 1);
    check("midrun_running0",   running,    0);
    check("midrun_done",       done,       0);
    check("midrun_status",     status,     0);
    check("midrun_cycles",     cycles,     0);
    rst_n = 1'b1;

    // Reset wins over a simultaneous restart.
    restart = 1'b1;
    rst_n   = 1'b0;
    tick();
    restart = 1'b0;
    rst_n   = 1'b1;

    // Randomised runs with occasional restart and reset pulses.
    for (int r = 0; r < 40; r++) begin
      pulse_restart();
      run_mode(6, 60);
      repeat (2) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
